dcache_line_adaptor: RTL and testbench
======================================

# dcache_line_adaptor

Memory-side responder for the data cache's physical-memory port. Accepts a full 256-bit line read or writeback request from the dcache (`pmem_*`) and completes it as a 4-beat, 64-bit burst on the main memory bus (`mem_*`). Returns a single-cycle `pmem_resp` when the whole line has transferred. Sits between the dcache datapath/control and the arbiter/physical memory.

## Interface
- `LINE_W`, 256, cache line width in bits
- `BEAT_W`, 64, memory bus width in bits; `BEATS = LINE_W/BEAT_W` (4); beat counter is `$clog2(BEATS)` bits
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pmem_address`  in  32  line address from dcache (selected by its mamux)
- `pmem_read`  in  1  line read request; held until `pmem_resp`
- `pmem_write`  in  1  line writeback request; held until `pmem_resp`
- `pmem_wdata`  in  LINE_W  writeback line
- `pmem_rdata`  out  LINE_W  assembled read line
- `pmem_resp`  out  1  one-cycle completion pulse
- `mem_address`  out  32  burst base address, 32-byte aligned
- `mem_read`  out  1  burst read request
- `mem_write`  out  1  burst write request
- `mem_wdata`  out  BEAT_W  current write beat
- `mem_rdata`  in  BEAT_W  current read beat
- `mem_resp`  in  1  beat accepted (write) / beat valid (read)

## Operation
- States: IDLE, READ, WRITE, RESP. Registers: state, beat counter `cnt`, address latch, LINE_W line buffer.
- IDLE: if `pmem_write` -> latch address and `pmem_wdata` into buffer, `cnt`=0, go WRITE. Else if `pmem_read` -> latch address, `cnt`=0, go READ. Write has priority when both are high.
- READ: `mem_read`=1. On each cycle with `mem_resp`=1, store `mem_rdata` into buffer bits `[BEAT_W*cnt +: BEAT_W]`, `cnt`++. On the beat with `cnt`==BEATS-1, go RESP.
- WRITE: `mem_write`=1, `mem_wdata` = buffer slice `cnt`. Advance `cnt` on `mem_resp`. Last beat -> RESP.
- RESP: `pmem_resp`=1 for exactly this cycle, then IDLE. Requests are not sampled in RESP.
- Beat order: beat 0 = line bits [63:0], ascending.
- `mem_address` = `{addr_latch[31:5], 5'b0}` throughout the burst. Low bits of `pmem_address` are ignored.
- `pmem_rdata` = line buffer, driven continuously. Valid in RESP and stable until the next request is accepted.
- `mem_resp` outside READ/WRITE is ignored. `pmem_address`/`pmem_wdata` changes after acceptance have no effect.
- `mem_read`/`mem_write` are never both high. Both are low in IDLE and RESP.

## Timing
- Reset: state=IDLE, `cnt`=0, buffer=0, address latch=0. Outputs after reset: `pmem_resp`=0, `pmem_rdata`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_wdata`=0.
- Request seen in IDLE at cycle 0 -> `mem_read`/`mem_write` high from cycle 1.
- With `mem_resp` high on cycles 1–4, `pmem_resp` is high in cycle 5. Minimum latency is request-to-resp = BEATS+1 cycles. Each stall cycle (`mem_resp`=0) adds one cycle.
- `mem_read`/`mem_write` stay high, unbroken, from cycle 1 through the last beat cycle, and drop in RESP.
- The dcache deasserts its request in the cycle after `pmem_resp`. The adaptor is back in IDLE then, so there is no retrigger.
- A new request asserted in that IDLE cycle is accepted immediately, giving back-to-back throughput of one line per BEATS+2 cycles.
- `rst` mid-burst: the next cycle is IDLE with all outputs at reset values. The partial line is discarded and no `pmem_resp` is issued.

## Test plan
- Read, no stalls:
  - Stimulus: `pmem_read`, addr 0x0000_1234; beats 0x1111…11, 0x2222…22, 0x3333…33, 0x4444…44 on cycles 1–4.
  - Required: `mem_address`=0x0000_1220; `pmem_resp` only in cycle 5; `pmem_rdata`={0x4444…,0x3333…,0x2222…,0x1111…}.
- Read, stalls: `mem_resp` pattern 1,0,0,1,1,0,1 -> beats land in order, `pmem_resp` one cycle after the 4th accepted beat (cycle 8), `mem_read` held high continuously.
- Writeback:
  - Stimulus: `pmem_write`, `pmem_wdata`={0xDDDD…,0xCCCC…,0xBBBB…,0xAAAA…}.
  - Required: `mem_wdata` is 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD… on successive accepted beats; `pmem_wdata` changed mid-burst has no effect.
- Writeback then read (dirty eviction):
  - Stimulus: write to 0x100; after `pmem_resp`, read of 0x200 asserted the next cycle.
  - Required: read accepted in that cycle, `mem_read` high one cycle later, no `pmem_resp` duplicates.
- Simultaneous `pmem_read` and `pmem_write` in IDLE -> WRITE burst only; `mem_read` stays 0.
- `rst` asserted after beat 2 of a read -> all outputs at reset values the next cycle, no `pmem_resp`; a subsequent read completes normally with fresh data.

Source files
------------

// File: rtl/dcache_line_adaptor.sv
// dcache_line_adaptor: turns a single 256-bit dcache line read or writeback
// into a 4-beat, 64-bit burst on the main memory bus. When the whole line has
// moved, it returns a one-cycle completion pulse to the dcache.
module dcache_line_adaptor #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // dcache side
    input  logic [31:0]       i_pmem_address,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] o_pmem_rdata,
    output logic              o_pmem_resp,
    // memory bus side
    output logic [31:0]       o_mem_address,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [BEAT_W-1:0] o_mem_wdata,
    input  logic [BEAT_W-1:0] i_mem_rdata,
    input  logic              i_mem_resp
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [LINE_W-1:0] r_line;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_pmem_resp;
    logic [BEAT_W-1:0] w_wbeat;

    // Current write beat: the slice of the line buffer at the beat counter
    assign w_wbeat = r_line[BEAT_W*r_cnt +: BEAT_W];

    // Burst sequencer: accept a request, stream its beats, then pulse resp
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_line      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_pmem_resp <= 1'b0;
        end else begin
            r_pmem_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Writeback wins when both requests arrive together
                    if (i_pmem_write) begin
                        r_addr      <= i_pmem_address;
                        r_line      <= i_pmem_wdata;
                        r_cnt       <= '0;
                        r_mem_write <= 1'b1;
                        r_state     <= S_WRITE;
                    end else if (i_pmem_read) begin
                        r_addr     <= i_pmem_address;
                        r_cnt      <= '0;
                        r_mem_read <= 1'b1;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (i_mem_resp) begin
                        r_line[BEAT_W*r_cnt +: BEAT_W] <= i_mem_rdata;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BEAT) begin
                            r_mem_read  <= 1'b0;
                            r_pmem_resp <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_WRITE: begin
                    if (i_mem_resp) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BEAT) begin
                            r_mem_write <= 1'b0;
                            r_pmem_resp <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    // Requests are deliberately not sampled here; the dcache drops
                    // its request next cycle, so there is no retrigger
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pmem_rdata  = r_line;
    assign o_pmem_resp   = r_pmem_resp;
    assign o_mem_address = {r_addr[31:OFF_W], OFF_W'(0)};
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;
    assign o_mem_wdata   = w_wbeat;

endmodule

// File: tb/tb_dcache_line_adaptor.sv
// Testbench for dcache_line_adaptor: a per-cycle vector table covers reads,
// stalls, writeback and a back-to-back eviction. Hand-written sequences cover
// simultaneous requests and reset in the middle of a burst.
module tb_dcache_line_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    int checks = 0;
    int errors = 0;

    dcache_line_adaptor #(.LINE_W(256), .BEAT_W(64)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pmem_address(pmem_address),
        .i_pmem_read   (pmem_read),
        .i_pmem_write  (pmem_write),
        .i_pmem_wdata  (pmem_wdata),
        .o_pmem_rdata  (pmem_rdata),
        .o_pmem_resp   (pmem_resp),
        .o_mem_address (mem_address),
        .o_mem_read    (mem_read),
        .o_mem_write   (mem_write),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .i_mem_resp    (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic         mresp;
        logic [63:0]  mrdata;
        logic [255:0] wdata;
        logic         e_rd;
        logic         e_wr;
        logic         e_resp;
        logic [31:0]  e_addr;
        logic         wd_chk;
        logic [63:0]  e_wd;
    } vec_t;

    vec_t vt[$];

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic mresp, input logic [63:0] mrdata,
                                input logic [255:0] wdata, input logic e_rd, input logic e_wr,
                                input logic e_resp, input logic [31:0] e_addr,
                                input logic wd_chk, input logic [63:0] e_wd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.mresp = mresp; v.mrdata = mrdata;
        v.wdata = wdata; v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp;
        v.e_addr = e_addr; v.wd_chk = wd_chk; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pmem_read    = vt[i].rd;
            pmem_write   = vt[i].wr;
            pmem_address = vt[i].addr;
            pmem_wdata   = vt[i].wdata;
            mem_resp     = vt[i].mresp;
            mem_rdata    = vt[i].mrdata;
            chk($sformatf("vec%0d mem_read", i), 256'(mem_read), 256'(vt[i].e_rd));
            chk($sformatf("vec%0d mem_write", i), 256'(mem_write), 256'(vt[i].e_wr));
            chk($sformatf("vec%0d pmem_resp", i), 256'(pmem_resp), 256'(vt[i].e_resp));
            chk($sformatf("vec%0d mem_address", i), 256'(mem_address), 256'(vt[i].e_addr));
            if (vt[i].wd_chk)
                chk($sformatf("vec%0d mem_wdata", i), 256'(mem_wdata), 256'(vt[i].e_wd));
            step();
        end
    endtask

    localparam logic [63:0]  JUNK = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0]  RD0  = 64'h1234_5678_9ABC_DEF0;

    initial begin
        logic [255:0] wl;
        logic [255:0] garb;
        logic [255:0] wl2;
        logic [255:0] zl;
        int resp_seen;

        wl   = {rep(8'hDD), rep(8'hCC), rep(8'hBB), rep(8'hAA)};
        garb = {4{64'h0BAD_0BAD_0BAD_0BAD}};
        wl2  = {rep(8'h04), rep(8'h03), rep(8'h02), rep(8'h01)};
        zl   = '0;

        // Segment A: read 0x1234, no stalls (vectors 0-6)
        vt.push_back(mk(1, 0, 32'h1234, 0, 64'h0,      zl, 0, 0, 0, 32'h0,    0, 64'h0));
        vt.push_back(mk(1, 0, 32'h1234, 1, rep(8'h11), zl, 1, 0, 0, 32'h1220, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h1234, 1, rep(8'h22), zl, 1, 0, 0, 32'h1220, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h1234, 1, rep(8'h33), zl, 1, 0, 0, 32'h1220, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h1234, 1, rep(8'h44), zl, 1, 0, 0, 32'h1220, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h1234, 0, 64'h0,      zl, 0, 0, 1, 32'h1220, 0, 64'h0));
        vt.push_back(mk(0, 0, 32'h1234, 0, 64'h0,      zl, 0, 0, 0, 32'h1220, 0, 64'h0));
        // Segment B: read 0x40 with stall pattern 1,0,0,1,1,0,1 (vectors 7-16)
        vt.push_back(mk(1, 0, 32'h40, 0, 64'h0,      zl, 0, 0, 0, 32'h1220, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h40, 1, rep(8'h55), zl, 1, 0, 0, 32'h40,   0, 64'h0));
        vt.push_back(mk(1, 0, 32'h40, 0, JUNK,       zl, 1, 0, 0, 32'h40,   0, 64'h0));
        vt.push_back(mk(1, 0, 32'h40, 0, JUNK,       zl, 1, 0, 0, 32'h40,   0, 64'h0));
        vt.push_back(mk(1, 0, 32'h40, 1, rep(8'h66), zl, 1, 0, 0, 32'h40,   0, 64'h0));
        vt.push_back(mk(1, 0, 32'h40, 1, rep(8'h77), zl, 1, 0, 0, 32'h40,   0, 64'h0));
        vt.push_back(mk(1, 0, 32'h40, 0, JUNK,       zl, 1, 0, 0, 32'h40,   0, 64'h0));
        vt.push_back(mk(1, 0, 32'h40, 1, rep(8'h88), zl, 1, 0, 0, 32'h40,   0, 64'h0));
        vt.push_back(mk(1, 0, 32'h40, 1, JUNK,       zl, 0, 0, 1, 32'h40,   0, 64'h0));
        vt.push_back(mk(0, 0, 32'h40, 1, JUNK,       zl, 0, 0, 0, 32'h40,   0, 64'h0));
        // Segment C: writeback 0x100 then read 0x200 right after resp (vectors 17-30)
        vt.push_back(mk(0, 1, 32'h100, 0, 64'h0,      wl,   0, 0, 0, 32'h40,  0, 64'h0));
        vt.push_back(mk(0, 1, 32'h100, 1, 64'h0,      wl,   0, 1, 0, 32'h100, 1, rep(8'hAA)));
        vt.push_back(mk(0, 1, 32'h1FF, 0, 64'h0,      garb, 0, 1, 0, 32'h100, 1, rep(8'hBB)));
        vt.push_back(mk(0, 1, 32'h1FF, 1, 64'h0,      garb, 0, 1, 0, 32'h100, 1, rep(8'hBB)));
        vt.push_back(mk(0, 1, 32'h1FF, 1, 64'h0,      garb, 0, 1, 0, 32'h100, 1, rep(8'hCC)));
        vt.push_back(mk(0, 1, 32'h1FF, 1, 64'h0,      garb, 0, 1, 0, 32'h100, 1, rep(8'hDD)));
        vt.push_back(mk(0, 1, 32'h1FF, 0, 64'h0,      garb, 0, 0, 1, 32'h100, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h200, 1, JUNK,       zl,   0, 0, 0, 32'h100, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h200, 1, rep(8'h99), zl,   1, 0, 0, 32'h200, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h200, 1, rep(8'hEE), zl,   1, 0, 0, 32'h200, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h200, 1, RD0,        zl,   1, 0, 0, 32'h200, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h200, 1, rep(8'h0F), zl,   1, 0, 0, 32'h200, 0, 64'h0));
        vt.push_back(mk(1, 0, 32'h200, 0, 64'h0,      zl,   0, 0, 1, 32'h200, 0, 64'h0));
        vt.push_back(mk(0, 0, 32'h200, 0, 64'h0,      zl,   0, 0, 0, 32'h200, 0, 64'h0));

        // Reset
        rst = 1'b1; pmem_read = 0; pmem_write = 0; pmem_address = '0;
        pmem_wdata = '0; mem_resp = 0; mem_rdata = '0;
        step();
        step();
        chk("reset pmem_resp", 256'(pmem_resp), 256'(0));
        chk("reset pmem_rdata", pmem_rdata, 256'(0));
        chk("reset mem_read", 256'(mem_read), 256'(0));
        chk("reset mem_write", 256'(mem_write), 256'(0));
        chk("reset mem_address", 256'(mem_address), 256'(0));
        chk("reset mem_wdata", 256'(mem_wdata), 256'(0));
        rst = 1'b0;

        run_vec(0, 6);
        chk("A pmem_rdata", pmem_rdata, {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)});
        run_vec(7, 16);
        chk("B pmem_rdata", pmem_rdata, {rep(8'h88), rep(8'h77), rep(8'h66), rep(8'h55)});
        run_vec(17, 30);
        chk("C pmem_rdata", pmem_rdata, {rep(8'h0F), RD0, rep(8'hEE), rep(8'h99)});

        // D: simultaneous read and write -> writeback burst only
        pmem_read = 1; pmem_write = 1; pmem_address = 32'h300; pmem_wdata = wl2; mem_resp = 0;
        step();
        for (int b = 0; b < 4; b++) begin
            mem_resp = 1;
            chk($sformatf("D beat%0d mem_read", b), 256'(mem_read), 256'(0));
            chk($sformatf("D beat%0d mem_write", b), 256'(mem_write), 256'(1));
            chk($sformatf("D beat%0d mem_wdata", b), 256'(mem_wdata), 256'(rep(8'(b + 1))));
            step();
        end
        chk("D pmem_resp", 256'(pmem_resp), 256'(1));
        chk("D resp mem_read", 256'(mem_read), 256'(0));
        pmem_read = 0; pmem_write = 0; mem_resp = 0;
        step();
        chk("D resp drops", 256'(pmem_resp), 256'(0));

        // E: reset after two read beats discards the burst
        pmem_read = 1; pmem_address = 32'h400; mem_resp = 0;
        step();
        mem_resp = 1; mem_rdata = rep(8'hA1);
        step();
        mem_rdata = rep(8'hA2);
        step();
        mem_resp = 0; pmem_read = 0; rst = 1;
        chk("E mem_read before rst", 256'(mem_read), 256'(1));
        step();
        rst = 0;
        chk("E rst pmem_resp", 256'(pmem_resp), 256'(0));
        chk("E rst pmem_rdata", pmem_rdata, 256'(0));
        chk("E rst mem_read", 256'(mem_read), 256'(0));
        chk("E rst mem_write", 256'(mem_write), 256'(0));
        chk("E rst mem_address", 256'(mem_address), 256'(0));
        chk("E rst mem_wdata", 256'(mem_wdata), 256'(0));
        resp_seen = 0;
        mem_resp = 1; mem_rdata = JUNK;
        for (int c = 0; c < 6; c++) begin
            if (pmem_resp) resp_seen++;
            step();
        end
        chk("E no stray resp", 256'(resp_seen), 256'(0));
        mem_resp = 0; pmem_read = 1; pmem_address = 32'h48C;
        step();
        for (int b = 0; b < 4; b++) begin
            mem_resp = 1; mem_rdata = rep(8'(8'hB1 + b));
            step();
        end
        mem_resp = 0;
        chk("E2 pmem_resp", 256'(pmem_resp), 256'(1));
        chk("E2 mem_address", 256'(mem_address), 256'(32'h480));
        chk("E2 pmem_rdata", pmem_rdata, {rep(8'hB4), rep(8'hB3), rep(8'hB2), rep(8'hB1)});
        pmem_read = 0;
        step();
        chk("E2 resp drops", 256'(pmem_resp), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
